// File: rtl/accel_decimation_filter_if.sv
// Sample-in / FIFO-write-out bundle for the boxcar decimator.
// The slave modport is the filter; the master modport drives samples and config and consumes writes.
interface accel_decimation_filter_if #(
    parameter int IN_WIDTH  = 20,
    parameter int OUT_WIDTH = 24,
    parameter int MAX_SHIFT = 4
);
    logic                        filter_en;
    logic [2:0]                  dec_shift;
    logic                        sample_valid;
    logic signed [IN_WIDTH-1:0]  sample_data;
    logic                        wr_en;
    logic signed [OUT_WIDTH-1:0] filter_fifo_data;
    logic [MAX_SHIFT:0]          block_cnt;

    modport slave (
        input  filter_en,
        input  dec_shift,
        input  sample_valid,
        input  sample_data,
        output wr_en,
        output filter_fifo_data,
        output block_cnt
    );

    modport master (
        output filter_en,
        output dec_shift,
        output sample_valid,
        output sample_data,
        input  wr_en,
        input  filter_fifo_data,
        input  block_cnt
    );
endinterface

// File: rtl/accel_decimation_filter.sv
// Boxcar-averaging decimator: sums blocks of 2^shift raw samples and writes the
// floor-shifted average straight into the per-axis FIFO (no backpressure).
module accel_decimation_filter #(
    parameter int IN_WIDTH  = 20,
    parameter int OUT_WIDTH = 24,
    parameter int MAX_SHIFT = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    accel_decimation_filter_if.slave    bus
);
    localparam int ACC_W = IN_WIDTH + MAX_SHIFT;
    localparam int CNT_W = MAX_SHIFT + 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    function automatic logic [2:0] clamp_shift(input logic [2:0] s);
        if (s > 3'(MAX_SHIFT)) begin
            return 3'(MAX_SHIFT);
        end else begin
            return s;
        end
    endfunction

    state_t                      state_r;
    logic [2:0]                  shift_r;
    logic signed [ACC_W-1:0]     acc_r;
    logic [CNT_W-1:0]            cnt_r;
    logic                        wr_en_r;
    logic signed [OUT_WIDTH-1:0] data_r;

    logic [2:0]                  shift_next_s;
    logic                        cfg_change_s;
    logic signed [IN_WIDTH-1:0]  sample_s;
    logic signed [ACC_W-1:0]     sum_s;
    logic signed [ACC_W-1:0]     avg_s;
    logic [CNT_W-1:0]            last_idx_s;

    // Next-sum, block-end index and floor average for the sample on this edge.
    always_comb begin
        shift_next_s = clamp_shift(bus.dec_shift);
        cfg_change_s = 1'b0;
        if (shift_next_s != shift_r) begin
            cfg_change_s = 1'b1;
        end else begin
            cfg_change_s = 1'b0;
        end
        sample_s   = bus.sample_data;
        sum_s      = acc_r + ACC_W'(sample_s);
        avg_s      = sum_s >>> shift_r;
        last_idx_s = (CNT_W'(1) << shift_r) - CNT_W'(1);
    end

    // Enable FSM, block accumulation and registered FIFO write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            shift_r <= 3'd0;
            acc_r   <= '0;
            cnt_r   <= '0;
            wr_en_r <= 1'b0;
            data_r  <= '0;
        end else begin
            wr_en_r <= 1'b0;
            // A shift change restarts the block regardless of state; the edge's sample is dropped.
            if (cfg_change_s) begin
                shift_r <= shift_next_s;
                acc_r   <= '0;
                cnt_r   <= '0;
                if (bus.filter_en) begin
                    state_r <= ACCUM;
                end else begin
                    state_r <= IDLE;
                end
            end else begin
                case (state_r)
                    IDLE: begin
                        acc_r <= '0;
                        cnt_r <= '0;
                        if (bus.filter_en) begin
                            state_r <= ACCUM;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    ACCUM: begin
                        if (!bus.filter_en) begin
                            state_r <= IDLE;
                            acc_r   <= '0;
                            cnt_r   <= '0;
                        end else if (bus.sample_valid) begin
                            if (cnt_r == last_idx_s) begin
                                data_r  <= OUT_WIDTH'(avg_s);
                                wr_en_r <= 1'b1;
                                acc_r   <= '0;
                                cnt_r   <= '0;
                            end else begin
                                acc_r <= sum_s;
                                cnt_r <= cnt_r + CNT_W'(1);
                            end
                        end else begin
                            acc_r <= acc_r;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        acc_r   <= '0;
                        cnt_r   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.wr_en            = wr_en_r;
    assign bus.filter_fifo_data = data_r;
    assign bus.block_cnt        = cnt_r;
endmodule

// File: tb/tb_accel_decimation_filter.sv
// Self-checking bench for accel_decimation_filter: directed scenarios plus random
// traffic, all compared against a block-list reference model of the decimator.
module tb_accel_decimation_filter;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    accel_decimation_filter_if #(.IN_WIDTH(20), .OUT_WIDTH(24), .MAX_SHIFT(4)) bus ();

    accel_decimation_filter #(.IN_WIDTH(20), .OUT_WIDTH(24), .MAX_SHIFT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the block is simply the list of samples collected so far.
    int          m_block[$];
    int          m_shift;
    bit          m_on;
    logic        exp_wr;
    logic [23:0] exp_data;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_block.delete();
        m_shift  = 0;
        m_on     = 1'b0;
        exp_wr   = 1'b0;
        exp_data = 24'd0;
    endtask

    task automatic model_edge(input logic en, input logic [2:0] ds, input logic v, input logic [19:0] d);
        int c;
        int n;
        int sum;
        int q;
        c      = (ds > 3'd4) ? 4 : int'(ds);
        exp_wr = 1'b0;
        if (c != m_shift) begin
            m_shift = c;
            m_block.delete();
        end else if (!m_on || !en) begin
            m_block.delete();
        end else if (v) begin
            m_block.push_back(int'($signed(d)));
            n = 1 << m_shift;
            if (m_block.size() == n) begin
                sum = 0;
                foreach (m_block[i]) sum += m_block[i];
                q = sum / n;
                if ((sum % n != 0) && (sum < 0)) q = q - 1;
                exp_data = q[23:0];
                exp_wr   = 1'b1;
                m_block.delete();
            end
        end
        m_on = en;
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".wr_en"}, {31'd0, bus.wr_en}, {31'd0, exp_wr});
        check_eq({tag, ".data"}, {8'd0, bus.filter_fifo_data}, {8'd0, exp_data});
        check_eq({tag, ".cnt"}, {27'd0, bus.block_cnt}, 32'(m_block.size()));
    endtask

    // One clock: apply inputs, let the edge happen, step the model, compare 1 ns later.
    task automatic cyc(input logic en, input logic [2:0] ds, input logic v, input logic [19:0] d, input string tag);
        bus.filter_en    = en;
        bus.dec_shift    = ds;
        bus.sample_valid = v;
        bus.sample_data  = d;
        @(posedge clk);
        model_edge(en, ds, v, d);
        #1;
        compare_all(tag);
    endtask

    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all(tag);
        bus.filter_en    = 1'b0;
        bus.sample_valid = 1'b0;
        @(posedge clk);
        #4;
        rst_n = 1'b1;
        #1;
        compare_all({tag, ".rel"});
    endtask

    initial begin
        logic       en;
        logic       prev_en;
        logic [2:0] ds;
        logic       v;
        logic [19:0] d;
        checks   = 0;
        failures = 0;
        bus.filter_en    = 1'b0;
        bus.dec_shift    = 3'd0;
        bus.sample_valid = 1'b0;
        bus.sample_data  = 20'd0;
        rst_n            = 1'b1;
        model_reset();
        #2;
        async_reset("reset");

        // N=1: every sample is written the next cycle.
        cyc(1'b1, 3'd0, 1'b0, 20'd0, "n1.en");
        cyc(1'b1, 3'd0, 1'b1, 20'h00005, "n1.s0");
        check_eq("n1.pos", {8'd0, bus.filter_fifo_data}, 32'h000005);
        cyc(1'b1, 3'd0, 1'b1, 20'hFFFFB, "n1.s1");
        check_eq("n1.neg", {8'd0, bus.filter_fifo_data}, 32'hFFFFFB);
        cyc(1'b1, 3'd0, 1'b0, 20'd0, "n1.idle");

        // N=4, block 10,20,30,41.
        cyc(1'b1, 3'd2, 1'b0, 20'd0, "n4.cfg");
        cyc(1'b1, 3'd2, 1'b1, 20'd10, "n4.s0");
        cyc(1'b1, 3'd2, 1'b1, 20'd20, "n4.s1");
        cyc(1'b1, 3'd2, 1'b1, 20'd30, "n4.s2");
        cyc(1'b1, 3'd2, 1'b1, 20'd41, "n4.s3");
        check_eq("n4.avg", {8'd0, bus.filter_fifo_data}, 32'd25);

        // N=16 full-scale negative and positive.
        cyc(1'b1, 3'd4, 1'b0, 20'd0, "n16.cfg");
        for (int i = 0; i < 16; i++) cyc(1'b1, 3'd4, 1'b1, 20'h80000, "n16.neg");
        check_eq("n16.negfs", {8'd0, bus.filter_fifo_data}, 32'hF80000);
        for (int i = 0; i < 16; i++) cyc(1'b1, 3'd4, 1'b1, 20'h7FFFF, "n16.pos");
        check_eq("n16.posfs", {8'd0, bus.filter_fifo_data}, 32'h07FFFF);

        // N=2 floor behaviour.
        cyc(1'b1, 3'd1, 1'b0, 20'd0, "n2.cfg");
        cyc(1'b1, 3'd1, 1'b1, 20'hFFFFF, "n2.a0");
        cyc(1'b1, 3'd1, 1'b1, 20'hFFFFE, "n2.a1");
        check_eq("n2.floor", {8'd0, bus.filter_fifo_data}, 32'hFFFFFE);
        cyc(1'b1, 3'd1, 1'b1, 20'd1, "n2.b0");
        cyc(1'b1, 3'd1, 1'b1, 20'd2, "n2.b1");
        check_eq("n2.pos", {8'd0, bus.filter_fifo_data}, 32'd1);

        // Shift change mid-block with a sample on that edge; 7 clamps to 4.
        cyc(1'b1, 3'd2, 1'b0, 20'd0, "cfg.a");
        cyc(1'b1, 3'd2, 1'b1, 20'd1, "cfg.s0");
        cyc(1'b1, 3'd2, 1'b1, 20'd1, "cfg.s1");
        cyc(1'b1, 3'd7, 1'b1, 20'd9, "cfg.chg");
        check_eq("cfg.cnt0", {27'd0, bus.block_cnt}, 32'd0);
        for (int i = 0; i < 16; i++) cyc(1'b1, 3'd7, 1'b1, 20'd1, "cfg.blk");
        check_eq("cfg.avg", {8'd0, bus.filter_fifo_data}, 32'd1);

        // filter_en gap mid-block discards the partial block.
        cyc(1'b1, 3'd2, 1'b0, 20'd0, "gap.cfg");
        for (int i = 0; i < 3; i++) cyc(1'b1, 3'd2, 1'b1, 20'd100, "gap.pre");
        for (int i = 0; i < 3; i++) cyc(1'b0, 3'd2, 1'b0, 20'd0, "gap.off");
        cyc(1'b1, 3'd2, 1'b0, 20'd0, "gap.on");
        for (int i = 0; i < 4; i++) cyc(1'b1, 3'd2, 1'b1, 20'd4, "gap.blk");
        check_eq("gap.avg", {8'd0, bus.filter_fifo_data}, 32'd4);

        // Async reset mid-block.
        for (int i = 0; i < 3; i++) cyc(1'b1, 3'd2, 1'b1, 20'd7, "rst.pre");
        async_reset("rst.mid");
        cyc(1'b1, 3'd2, 1'b0, 20'd0, "rst.post0");
        cyc(1'b1, 3'd2, 1'b1, 20'd7, "rst.post1");

        // Random traffic; enable only rises on cycles without a sample.
        prev_en = 1'b1;
        ds      = 3'd2;
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 19) != 0) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 39) == 0) ds = 3'($urandom_range(0, 7));
            v = ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0;
            if (en && !prev_en) v = 1'b0;
            d = 20'($urandom());
            cyc(en, ds, v, d, "rand");
            prev_en = en;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
